// File: rtl/cpu_pkg.sv
// Shared core definitions: store subtypes, store opcode, ROB tag width.
// Imported by the store reservation station and its age matrix.
package cpu_pkg;

  localparam logic [2:0] SB_OP = 3'b000;
  localparam logic [2:0] SH_OP = 3'b001;
  localparam logic [2:0] SW_OP = 3'b010;

  localparam logic [6:0] STORE_OP = 7'b0100011;

  localparam int unsigned RS_TAG_W = 6;
  typedef logic [RS_TAG_W-1:0] rs_tag_t;

  function automatic logic is_store_sub(
    input logic [2:0] s
  );
    return (s == SB_OP) || (s == SH_OP) || (s == SW_OP);
  endfunction

endpackage

// File: rtl/store_rs_age_matrix.sv
// Age matrix for the store station: age_q[i][j] = entry i older than j.
// Yields the oldest entry of a ready vector as a one-hot select.
module store_rs_age_matrix
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] rdy,
  output logic [DEPTH-1:0] oldest_oh
);

  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
  logic [DEPTH-1:0]            keep;
  logic [DEPTH-1:0]            blk;

  assign keep = valid & ~free_oh;

  // new entry is younger than every surviving entry
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (flush || free_oh[i] || free_oh[j] || i == j)
          age_d[i][j] = 1'b0;
        else if (alloc_oh[j])
          age_d[i][j] = keep[i];
        else if (alloc_oh[i])
          age_d[i][j] = 1'b0;
      end
    end
  end

  // matrix state register
  always_ff @(posedge clock) begin
    if (!reset) age_q <= '0;
    else        age_q <= age_d;
  end

  // ready entry with no older ready entry wins
  always_comb begin
    blk       = '0;
    oldest_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (rdy[j] && age_q[j][i]) blk[i] = 1'b1;
      end
      oldest_oh[i] = rdy[i] && !blk[i];
    end
  end

endmodule

// File: rtl/store_rs_multi.sv
// Multi-CDB store reservation station, age-ordered registered issue.
// STORE_RS_BYPASS_EN: capture same-cycle CDB data at dispatch.
module store_rs_multi
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = RS_TAG_W,
  parameter int CDB_N = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [2:0]                 disp_subtype,
  input  logic [XLEN-1:0]            disp_val,
  input  logic [XLEN-1:0]            disp_base,
  input  logic [XLEN-1:0]            disp_off,
  input  logic                       disp_val_busy,
  input  logic                       disp_base_busy,
  input  logic [TAG_W-1:0]           disp_val_tag,
  input  logic [TAG_W-1:0]           disp_base_tag,
  input  logic [TAG_W-1:0]           disp_rob,
  input  logic [CDB_N-1:0]           cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]     cdb_tag,
  input  logic [CDB_N*XLEN-1:0]      cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [TAG_W-1:0]           iss_rob,
  output logic [XLEN-1:0]            iss_addr,
  output logic [XLEN-1:0]            iss_data,
  output logic [XLEN/8-1:0]          iss_be,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt
);

  localparam int BE_W = XLEN / 8;
  localparam int LO_W = $clog2(BE_W);
  localparam int IX_W = $clog2(DEPTH);
  localparam int FC_W = $clog2(DEPTH + 1);

  // lowest matching channel wins: {hit, data}
  function automatic logic [XLEN:0] cdb_find(
    input logic [TAG_W-1:0]       tag,
    input logic [CDB_N-1:0]       v,
    input logic [CDB_N*TAG_W-1:0] t,
    input logic [CDB_N*XLEN-1:0]  d
  );
    logic [XLEN:0] r;
    r = '0;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (v[k] && t[k*TAG_W +: TAG_W] == tag)
        r = {1'b1, d[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] vbsy_q, vbsy_d;
  logic [DEPTH-1:0] bbsy_q, bbsy_d;
  logic [2:0]       sub_q  [DEPTH];
  logic [2:0]       sub_d  [DEPTH];
  logic [TAG_W-1:0] rob_q  [DEPTH];
  logic [TAG_W-1:0] rob_d  [DEPTH];
  logic [TAG_W-1:0] vtag_q [DEPTH];
  logic [TAG_W-1:0] vtag_d [DEPTH];
  logic [TAG_W-1:0] btag_q [DEPTH];
  logic [TAG_W-1:0] btag_d [DEPTH];
  logic [XLEN-1:0]  val_q  [DEPTH];
  logic [XLEN-1:0]  val_d  [DEPTH];
  logic [XLEN-1:0]  base_q [DEPTH];
  logic [XLEN-1:0]  base_d [DEPTH];
  logic [XLEN-1:0]  off_q  [DEPTH];
  logic [XLEN-1:0]  off_d  [DEPTH];
  logic [XLEN:0]    vhit   [DEPTH];
  logic [XLEN:0]    bhit   [DEPTH];

  logic             iss_valid_q, iss_valid_d;
  logic [IX_W-1:0]  sel_q, sel_d;
  logic [TAG_W-1:0] iss_rob_q, iss_rob_d;
  logic [XLEN-1:0]  iss_addr_q, iss_addr_d;
  logic [XLEN-1:0]  iss_data_q, iss_data_d;
  logic [BE_W-1:0]  iss_be_q, iss_be_d;

  logic [DEPTH-1:0] sel_oh, free_oh, alloc_oh;
  logic [DEPTH-1:0] rdy, oldest_oh;
  logic [IX_W-1:0]  alloc_idx, pick_idx;
  logic             do_alloc, hs;

  logic [2:0]       s_sub;
  logic [XLEN-1:0]  s_val, s_addr, s_data;
  logic [XLEN-1:0]  d8, d16, d32;
  logic [BE_W-1:0]  s_mask, s_be;

`ifdef STORE_RS_BYPASS_EN
  logic [XLEN:0] dv_hit, db_hit;
  assign dv_hit = cdb_find(disp_val_tag, cdb_valid, cdb_tag, cdb_data);
  assign db_hit = cdb_find(disp_base_tag, cdb_valid, cdb_tag, cdb_data);
`endif

  // free count and lowest free slot from current occupancy
  always_comb begin
    free_cnt  = '0;
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_cnt  = free_cnt + FC_W'(1);
        alloc_idx = IX_W'(i);
      end
    end
  end

  assign disp_ready = ~&vld_q;
  assign do_alloc   = disp_valid && disp_ready && !flush &&
                      is_store_sub(disp_subtype);
  assign alloc_oh   = do_alloc ? (DEPTH'(1) << alloc_idx) : '0;
  assign sel_oh     = DEPTH'(1) << sel_q;
  assign hs         = iss_valid_q && iss_ready;
  assign free_oh    = hs ? sel_oh : '0;
  assign rdy        = vld_q & ~vbsy_q & ~bbsy_q &
                      ~(iss_valid_q ? sel_oh : '0);

  store_rs_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .alloc_oh  (alloc_oh),
    .free_oh   (free_oh),
    .valid     (vld_q),
    .rdy       (rdy),
    .oldest_oh (oldest_oh)
  );

  // encode the oldest-ready select
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest_oh[i]) pick_idx = IX_W'(i);
    end
  end

  // per-entry CDB lookup for both operands
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vhit[i] = cdb_find(vtag_q[i], cdb_valid, cdb_tag, cdb_data);
      bhit[i] = cdb_find(btag_q[i], cdb_valid, cdb_tag, cdb_data);
    end
  end

  // entry update: free, capture, allocate, flush wins
  always_comb begin
    vld_d  = vld_q;
    vbsy_d = vbsy_q;
    bbsy_d = bbsy_q;
    sub_d  = sub_q;
    rob_d  = rob_q;
    vtag_d = vtag_q;
    btag_d = btag_q;
    val_d  = val_q;
    base_d = base_q;
    off_d  = off_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_oh[i]) vld_d[i] = 1'b0;
      if (vld_q[i] && vbsy_q[i] && vhit[i][XLEN]) begin
        vbsy_d[i] = 1'b0;
        val_d[i]  = vhit[i][XLEN-1:0];
      end
      if (vld_q[i] && bbsy_q[i] && bhit[i][XLEN]) begin
        bbsy_d[i] = 1'b0;
        base_d[i] = bhit[i][XLEN-1:0];
      end
    end
    if (do_alloc) begin
      vld_d[alloc_idx]  = 1'b1;
      sub_d[alloc_idx]  = disp_subtype;
      rob_d[alloc_idx]  = disp_rob;
      val_d[alloc_idx]  = disp_val;
      vbsy_d[alloc_idx] = disp_val_busy;
      vtag_d[alloc_idx] = disp_val_tag;
      base_d[alloc_idx] = disp_base;
      bbsy_d[alloc_idx] = disp_base_busy;
      btag_d[alloc_idx] = disp_base_tag;
      off_d[alloc_idx]  = disp_off;
`ifdef STORE_RS_BYPASS_EN
      if (disp_val_busy && dv_hit[XLEN]) begin
        vbsy_d[alloc_idx] = 1'b0;
        val_d[alloc_idx]  = dv_hit[XLEN-1:0];
      end
      if (disp_base_busy && db_hit[XLEN]) begin
        bbsy_d[alloc_idx] = 1'b0;
        base_d[alloc_idx] = db_hit[XLEN-1:0];
      end
`endif
    end
    if (flush) vld_d = '0;
  end

  // effective address, byte lanes and replicated data
  always_comb begin
    s_sub  = sub_q[pick_idx];
    s_val  = val_q[pick_idx];
    s_addr = base_q[pick_idx] + off_q[pick_idx];
    for (int b = 0; b < XLEN; b++) begin
      d8[b]  = s_val[b % 8];
      d16[b] = s_val[b % 16];
      d32[b] = s_val[b % 32];
    end
    s_mask = BE_W'(15);
    s_data = d32;
    unique case (1'b1)
      (s_sub == SB_OP): begin
        s_mask = BE_W'(1);
        s_data = d8;
      end
      (s_sub == SH_OP): begin
        s_mask = BE_W'(3);
        s_data = d16;
      end
      default: begin
        s_mask = BE_W'(15);
        s_data = d32;
      end
    endcase
    s_be = s_mask << s_addr[LO_W-1:0];
  end

  // issue slot: hold while stalled, else load oldest ready
  always_comb begin
    iss_valid_d = iss_valid_q;
    sel_d       = sel_q;
    iss_rob_d   = iss_rob_q;
    iss_addr_d  = iss_addr_q;
    iss_data_d  = iss_data_q;
    iss_be_d    = iss_be_q;
    if (flush) begin
      iss_valid_d = 1'b0;
      sel_d       = '0;
      iss_rob_d   = '0;
      iss_addr_d  = '0;
      iss_data_d  = '0;
      iss_be_d    = '0;
    end else if (!iss_valid_q || iss_ready) begin
      iss_valid_d = |oldest_oh;
      if (|oldest_oh) begin
        sel_d      = pick_idx;
        iss_rob_d  = rob_q[pick_idx];
        iss_addr_d = s_addr;
        iss_data_d = s_data;
        iss_be_d   = s_be;
      end
    end
  end

  // entry and issue state registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q       <= '0;
      vbsy_q      <= '0;
      bbsy_q      <= '0;
      sub_q       <= '{default: '0};
      rob_q       <= '{default: '0};
      vtag_q      <= '{default: '0};
      btag_q      <= '{default: '0};
      val_q       <= '{default: '0};
      base_q      <= '{default: '0};
      off_q       <= '{default: '0};
      iss_valid_q <= 1'b0;
      sel_q       <= '0;
      iss_rob_q   <= '0;
      iss_addr_q  <= '0;
      iss_data_q  <= '0;
      iss_be_q    <= '0;
    end else begin
      vld_q       <= vld_d;
      vbsy_q      <= vbsy_d;
      bbsy_q      <= bbsy_d;
      sub_q       <= sub_d;
      rob_q       <= rob_d;
      vtag_q      <= vtag_d;
      btag_q      <= btag_d;
      val_q       <= val_d;
      base_q      <= base_d;
      off_q       <= off_d;
      iss_valid_q <= iss_valid_d;
      sel_q       <= sel_d;
      iss_rob_q   <= iss_rob_d;
      iss_addr_q  <= iss_addr_d;
      iss_data_q  <= iss_data_d;
      iss_be_q    <= iss_be_d;
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_rob   = iss_rob_q;
  assign iss_addr  = iss_addr_q;
  assign iss_data  = iss_data_q;
  assign iss_be    = iss_be_q;

endmodule

// File: doc/store_rs_multi.md
# store_rs_multi

Parametrised store reservation station for the out-of-order core: holds dispatched store instructions until their value and base-address operands arrive from the result broadcast (CDB) ports. It then issues the oldest ready store, fully formed with effective address and byte lanes, to the store unit. It sits between dispatch/rename and the load-store unit. It generalises the single-CDB, four-entry store station to `DEPTH` entries, `CDB_N` broadcast channels, age-ordered issue, a valid/ready issue handshake and flush.

## Interface
- `XLEN`, 32, data/address width; multiple of 8, at least 16.
- `DEPTH`, 4, number of entries; 2..16.
- `TAG_W`, 6, ROB tag width.
- `CDB_N`, 2, number of broadcast channels; 1..4.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `flush`  in  1  squash all entries (branch mispredict / exception).
- `disp_valid`, `disp_ready`  in/out  1  dispatch handshake; `disp_ready` = at least one free entry.
- `disp_subtype`  in  3  000 SB, 001 SH, 010 SW; other codes are ignored (no allocation).
- `disp_val`, `disp_base`, `disp_off`  in  XLEN  store value, base register, immediate offset.
- `disp_val_busy`, `disp_base_busy`  in  1  operand still pending.
- `disp_val_tag`, `disp_base_tag`  in  TAG_W  producer tag when busy.
- `disp_rob`  in  TAG_W  ROB entry of the store.
- `cdb_valid`  in  CDB_N  per-channel broadcast strobe.
- `cdb_tag`  in  CDB_N*TAG_W  packed per-channel tags.
- `cdb_data`  in  CDB_N*XLEN  packed per-channel data.
- `iss_valid`, `iss_ready`  out/in  1  issue handshake.
- `iss_rob`  out  TAG_W  ROB entry of the issued store.
- `iss_addr`  out  XLEN  `base + off`, wrapped modulo 2^XLEN.
- `iss_data`  out  XLEN  value shifted into lane position.
- `iss_be`  out  XLEN/8  byte enables.
- `free_cnt`  out  clog2(DEPTH+1)  free entries.

## Operation
- Entry fields:
  - valid
  - subtype
  - rob
  - val and val_busy / val_tag
  - base and base_busy / base_tag
  - off
- Allocate on `disp_valid && disp_ready` into the lowest-index free entry, which becomes youngest in age order.
- Capture: for each busy operand of each valid entry, if any `cdb_valid[k]` has a matching `cdb_tag[k]`, latch that channel's data and clear busy.
  - With multiple matching channels, the lowest k wins.
- Ready entry: valid, `val_busy == 0`, `base_busy == 0`.
- Selection: the oldest ready entry drives the `iss_*` outputs.
  - Once `iss_valid` is asserted, the selected entry and its payload are held stable until `iss_ready`, even if an older entry becomes ready.
- Issue handshake (`iss_valid && iss_ready`) frees the entry in that cycle.
- Lane formation, with `lo` = `iss_addr[clog2(XLEN/8)-1:0]`:
  - SB: `be = 1 << lo`; data = `val[7:0]` replicated to every byte.
  - SH: `be = 2'b11 << lo`; data = `val[15:0]` replicated.
  - SW: `be = 4'hF << lo`; data = `val[31:0]` replicated.
  - Bits shifted beyond `XLEN/8` are dropped.
  - Misalignment is not trapped here.
- Flush: all entries invalidated; `free_cnt = DEPTH`. Flush has priority over dispatch, capture and issue in the same cycle.
- Same-cycle issue-free plus dispatch on a full station: `disp_ready` is computed from the current state, so the freed slot becomes usable next cycle.
- Reset (`reset == 0`) clears everything regardless of `flush`. Output values during and after reset:
  - `iss_valid = 0`
  - `disp_ready = 1`
  - `free_cnt = DEPTH`
  - `iss_rob = 0`, `iss_addr = 0`, `iss_data = 0`, `iss_be = 0`

## Timing
- Dispatch at edge N: the entry is visible at N+1 and can be issued at the earliest at N+1 (`iss_valid` high after edge N+1 if both operands were not busy).
- CDB match at edge N: the operand is latched and the entry is issue-eligible from N+1.
- `iss_*` outputs are registered; the issue path has no combinational path from `cdb_*` or `disp_*`.
- `iss_ready` may combinationally feed only the entry-free logic.

## Configuration
- `STORE_RS_BYPASS_EN` defined: dispatch operands are also compared against the same-cycle CDB.
  - A busy dispatch operand whose tag is broadcast in the allocating cycle is stored as not-busy with the CDB data.
- Not defined: dispatch operands are stored exactly as presented. Upstream rename must guarantee that no tag is broadcast in the cycle it is dispatched as busy.

## Structure
- Shared package `cpu_pkg`:
  - store subtype constants `SB_OP`, `SH_OP`, `SW_OP`
  - `STORE_OP` opcode
  - the `rs_tag_t` width convention
- Sub-module `store_rs_age_matrix`, DEPTH×DEPTH age matrix:
  - set on allocate
  - cleared on free/flush
  - outputs a one-hot oldest-ready select from a ready vector

## Test plan
- Dispatch SW, val=0xDEADBEEF ready, base=0x1000 ready, off=4, rob=3 -> next cycle `iss_valid`, `iss_addr` = 0x1004, `iss_be` = 4'hF, `iss_rob` = 3.
- Dispatch SB with base busy on tag 7, val=0xAB; CDB channel 1 broadcasts tag 7 data=0x2003 -> `iss_addr` = 0x2003, `iss_be` = 4'b1000, `iss_data` = 0xABABABAB one cycle after the broadcast.
- Fill all 4 entries, hold `iss_ready` = 0 -> `disp_ready` = 0, `free_cnt` = 0; raise `iss_ready` for one cycle -> oldest rob issued, `free_cnt` = 1 the next cycle.
- Two entries become ready in the same cycle (rob 5 older than rob 9) -> rob 5 issues first, rob 9 issues on the following handshake.
- Assert `flush` with 3 valid entries and a concurrent dispatch -> next cycle `iss_valid` = 0, `free_cnt` = DEPTH.
- With `STORE_RS_BYPASS_EN` defined: dispatch with val busy on tag 2 while CDB channel 0 broadcasts tag 2 = 0x55 -> entry issues with data 0x55 and no further broadcast needed.
